branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor that feeds the PC register.
- Looks up the current fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Drives br_pred and new_pc_pred to the PC register within the same cycle.
- Trained by resolved-branch updates from execute. Keeps update and misprediction counts for the didactic platform's performance display.

Parameters:
- IDX_BITS, 4, log2 of BTB entry count (default 16 entries). Index = pc[IDX_BITS+1:2].
- TAG_BITS, 30-IDX_BITS, tag width. Tag = pc[31:IDX_BITS+2]. Derived; not overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pc  in  32  current fetch PC from the PC register
- br_pred  out  1  predict taken for pc
- new_pc_pred  out  32  predicted next PC
- upd_valid  in  1  execute reports a resolved branch/jump this cycle
- upd_pc  in  32  PC of the resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual taken target
- upd_mispred  in  1  prediction for upd_pc was wrong (qualifies miss_count only)
- upd_count  out  32  number of accepted updates
- miss_count  out  32  number of accepted updates with upd_mispred=1

Behaviour:
- Storage per entry: valid, tag[TAG_BITS], target[32], ctr[2].
- Storage is registers, not RAM, so that reset is single-cycle.
- Reset (sampled at posedge while reset=1):
  - All valid=0 and all ctr=2'b01 (weakly not-taken); tags/targets don't-care.
  - upd_count=0, miss_count=0.
  - upd_valid is ignored in any cycle where reset=1. A reset mid-training discards that update.
- Lookup is combinational on pc, with zero latency:
  - hit = valid[idx] && tag[idx]==pc tag.
  - br_pred = hit && ctr[idx][1].
  - new_pc_pred = br_pred ? target[idx] : pc+4 (32-bit wrap: 0xFFFFFFFC -> 0x00000000).
  - After reset, br_pred=0 and new_pc_pred=pc+4 for any pc.
- Update takes effect at the posedge where upd_valid=1 and reset=0. Entry = upd_pc index; uhit = valid && tag match.
  - uhit, taken: ctr=sat_inc(ctr) (max 2'b11); target=upd_target.
  - uhit, not taken: ctr=sat_dec(ctr) (min 2'b00); target unchanged.
  - miss, taken: allocate by overwriting (evicts alias). Set valid=1, tag=upd_pc tag, target=upd_target, ctr=2'b10.
  - miss, not taken: no change.
- Simultaneous lookup and update:
  - Lookup in the same cycle sees pre-update contents, including when indices are equal; there is no bypass.
  - The new state is visible from the next cycle.
- Counters:
  - upd_count increments on each accepted update.
  - miss_count increments when the update is accepted and upd_mispred=1.
  - Both saturate at 0xFFFFFFFF and do not wrap.
- Stall and misprediction flush are handled by the PC register. The predictor keeps no fetch-side state, so stall has no effect here.
- No X-propagation from the uninitialised tag/target fields: br_pred must be 0 whenever valid=0.

Test Plan:
- Reset with IDX_BITS=4, then pc=0x100 -> br_pred=0, new_pc_pred=0x104. upd_count=0, miss_count=0.
- Update upd_pc=0x100, taken=1, target=0x200, mispred=1. Next cycle pc=0x100 -> br_pred=1, new_pc_pred=0x200; upd_count=1, miss_count=1.
- From the entry at ctr=10, apply two not-taken updates for 0x100:
  - after the first, br_pred=0 (ctr=01);
  - after the second, ctr=00;
  - then two taken updates -> br_pred=1 only after the second.
  - Also check saturation at 11 and 00.
- Alias test:
  - After the 0x100 entry is allocated, a taken update at 0x140 (same idx 0, tag 5) with target 0x300 evicts it.
  - Then pc=0x100 -> br_pred=0, new_pc_pred=0x104; pc=0x140 -> br_pred=1, new_pc_pred=0x300.
- Same-cycle update and lookup at pc=0x180 (first allocation) -> br_pred=0 that cycle, br_pred=1 with the new target the next cycle.
- Other cases:
  - Assert reset together with upd_valid=1 -> the update is dropped and the table and counters are cleared.
  - pc=0xFFFFFFFC with no entry -> new_pc_pred=0x00000000.
  - Force upd_count to 0xFFFFFFFF and update -> the count stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-side predictor bus: lookup PC in, prediction out, resolved-branch training in, stats out.
// Latency: lookup is combinational; training takes effect on the next clock edge.
// Backpressure: none; every update presented with upd_valid is accepted.
interface branch_predictor_if;
    logic [31:0] pc;
    logic        br_pred;
    logic [31:0] new_pc_pred;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;
    logic [31:0] upd_count;
    logic [31:0] miss_count;

    modport master (
        output pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispred,
        input  br_pred, new_pc_pred, upd_count, miss_count
    );

    modport slave (
        input  pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispred,
        output br_pred, new_pc_pred, upd_count, miss_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; predicts the next fetch PC.
// Latency: zero-cycle lookup on pc; updates visible the cycle after upd_valid (no bypass).
// Backpressure: none; the predictor holds no fetch-side state, so stalls do not affect it.
module branch_predictor #(
    parameter int IDX_BITS = 4
) (
    input logic               clk,
    input logic               reset,
    branch_predictor_if.slave bp
);
    localparam int N        = 1 << IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    // Table state: registers so that one reset cycle clears every entry.
    logic                valid_q [N];
    logic [TAG_BITS-1:0] tag_q   [N];
    logic [31:0]         tgt_q   [N];
    logic [1:0]          ctr_q   [N];
    logic [31:0]         upd_count_q, upd_count_d;
    logic [31:0]         miss_count_q, miss_count_d;

    // Lookup side
    logic [IDX_BITS-1:0] l_idx;
    logic [TAG_BITS-1:0] l_tag;
    logic                l_hit;
    logic                l_pred;

    // Update side
    logic [IDX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0] u_tag;
    logic                u_hit;
    logic                ent_we;
    logic                ent_valid_d;
    logic [TAG_BITS-1:0] ent_tag_d;
    logic [31:0]         ent_tgt_d;
    logic [1:0]          ent_ctr_d;
    logic                upd_acc;

    // The low two PC bits never select an entry (word-aligned fetch).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pc[1:0], bp.upd_pc[1:0]};

    assign l_idx = bp.pc[IDX_BITS+1:2];
    assign l_tag = bp.pc[31:IDX_BITS+2];
    assign u_idx = bp.upd_pc[IDX_BITS+1:2];
    assign u_tag = bp.upd_pc[31:IDX_BITS+2];

    // Combinational prediction from pre-update contents; valid gates the uninitialised fields.
    always_comb begin
        l_hit  = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        l_pred = l_hit && ctr_q[l_idx][1];
        bp.br_pred     = l_pred;
        bp.new_pc_pred = l_pred ? tgt_q[l_idx] : (bp.pc + 32'd4);
    end

    assign bp.upd_count  = upd_count_q;
    assign bp.miss_count = miss_count_q;

    // Next-state for the single entry addressed by the update, plus saturating stats.
    always_comb begin
        upd_acc     = bp.upd_valid;
        u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        ent_we      = 1'b0;
        ent_valid_d = valid_q[u_idx];
        ent_tag_d   = tag_q[u_idx];
        ent_tgt_d   = tgt_q[u_idx];
        ent_ctr_d   = ctr_q[u_idx];
        if (upd_acc) begin
            if (u_hit) begin
                ent_we = 1'b1;
                if (bp.upd_taken) begin
                    ent_tgt_d = bp.upd_target;
                    if (ctr_q[u_idx] != 2'b11) ent_ctr_d = ctr_q[u_idx] + 2'd1;
                end else begin
                    if (ctr_q[u_idx] != 2'b00) ent_ctr_d = ctr_q[u_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                // Allocation overwrites whatever alias occupied the slot.
                ent_we      = 1'b1;
                ent_valid_d = 1'b1;
                ent_tag_d   = u_tag;
                ent_tgt_d   = bp.upd_target;
                ent_ctr_d   = 2'b10;
            end
        end

        upd_count_d  = upd_count_q;
        miss_count_d = miss_count_q;
        if (upd_acc && (upd_count_q != 32'hFFFF_FFFF))
            upd_count_d = upd_count_q + 32'd1;
        if (upd_acc && bp.upd_mispred && (miss_count_q != 32'hFFFF_FFFF))
            miss_count_d = miss_count_q + 32'd1;
    end

    // Table and stats registers; reset wins over any update presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
            upd_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            if (ent_we) begin
                valid_q[u_idx] <= ent_valid_d;
                tag_q[u_idx]   <= ent_tag_d;
                tgt_q[u_idx]   <= ent_tgt_d;
                ctr_q[u_idx]   <= ent_ctr_d;
            end
            upd_count_q  <= upd_count_d;
            miss_count_q <= miss_count_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for the BTB predictor with hand-computed expectations.
// Latency: inputs driven on the falling edge, outputs sampled 1ns later.
// Backpressure: not applicable; updates are single-cycle pulses.
module tb_branch_predictor;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    branch_predictor_if bp ();

    branch_predictor #(.IDX_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one update for a single clock, then drop upd_valid.
    task automatic do_upd(input logic [31:0] a, input logic t, input logic [31:0] tgt,
                          input logic m);
        bp.upd_valid   = 1'b1;
        bp.upd_pc      = a;
        bp.upd_taken   = t;
        bp.upd_target  = tgt;
        bp.upd_mispred = m;
        @(negedge clk);
        bp.upd_valid   = 1'b0;
        bp.upd_mispred = 1'b0;
    endtask

    // Look up a PC and compare both prediction outputs.
    task automatic look(input string tag, input logic [31:0] a, input logic p,
                        input logic [31:0] npc);
        bp.pc = a;
        #1;
        chk({tag, ".br_pred"}, {31'd0, bp.br_pred}, {31'd0, p});
        chk({tag, ".new_pc"}, bp.new_pc_pred, npc);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bp.pc          = 32'h100;
        bp.upd_valid   = 1'b0;
        bp.upd_pc      = 32'h0;
        bp.upd_taken   = 1'b0;
        bp.upd_target  = 32'h0;
        bp.upd_mispred = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        look("rst", 32'h100, 1'b0, 32'h104);
        chk("rst.upd_count", bp.upd_count, 32'd0);
        chk("rst.miss_count", bp.miss_count, 32'd0);

        // Allocate 0x100 -> 0x200, ctr=10
        do_upd(32'h100, 1'b1, 32'h200, 1'b1);
        look("alloc", 32'h100, 1'b1, 32'h200);
        chk("alloc.upd_count", bp.upd_count, 32'd1);
        chk("alloc.miss_count", bp.miss_count, 32'd1);

        // Counter walk down, saturate at 00, walk back up
        do_upd(32'h100, 1'b0, 32'h0, 1'b1);           // 10 -> 01
        look("nt1", 32'h100, 1'b0, 32'h104);
        do_upd(32'h100, 1'b0, 32'h0, 1'b0);           // 01 -> 00
        look("nt2", 32'h100, 1'b0, 32'h104);
        do_upd(32'h100, 1'b0, 32'h0, 1'b0);           // 00 stays 00
        do_upd(32'h100, 1'b1, 32'h240, 1'b0);         // 00 -> 01
        look("t1", 32'h100, 1'b0, 32'h104);
        do_upd(32'h100, 1'b1, 32'h240, 1'b1);         // 01 -> 10, target 0x240
        look("t2", 32'h100, 1'b1, 32'h240);
        do_upd(32'h100, 1'b1, 32'h240, 1'b0);         // 10 -> 11
        do_upd(32'h100, 1'b1, 32'h240, 1'b0);         // 11 stays 11
        do_upd(32'h100, 1'b0, 32'h0, 1'b0);           // 11 -> 10
        look("sat11", 32'h100, 1'b1, 32'h240);
        do_upd(32'h100, 1'b0, 32'h0, 1'b0);           // 10 -> 01
        look("down01", 32'h100, 1'b0, 32'h104);
        chk("walk.upd_count", bp.upd_count, 32'd10);
        chk("walk.miss_count", bp.miss_count, 32'd3);

        // Alias 0x140 shares idx 0 with tag 5, evicts 0x100
        do_upd(32'h140, 1'b1, 32'h300, 1'b0);
        look("alias.old", 32'h100, 1'b0, 32'h104);
        look("alias.new", 32'h140, 1'b1, 32'h300);

        // Same-cycle lookup and allocation at 0x180: no bypass
        bp.pc          = 32'h180;
        bp.upd_valid   = 1'b1;
        bp.upd_pc      = 32'h180;
        bp.upd_taken   = 1'b1;
        bp.upd_target  = 32'h400;
        bp.upd_mispred = 1'b0;
        #1;
        chk("same.br_pred", {31'd0, bp.br_pred}, 32'd0);
        chk("same.new_pc", bp.new_pc_pred, 32'h184);
        @(negedge clk);
        bp.upd_valid = 1'b0;
        look("same.next", 32'h180, 1'b1, 32'h400);
        look("same.evict", 32'h140, 1'b0, 32'h144);
        chk("same.upd_count", bp.upd_count, 32'd12);
        chk("same.miss_count", bp.miss_count, 32'd3);

        // PC wrap with no entry
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Stats saturation
        force dut.upd_count_q  = 32'hFFFF_FFFF;
        force dut.miss_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.upd_count_q;
        release dut.miss_count_q;
        do_upd(32'h500, 1'b0, 32'h0, 1'b1);
        #1;
        chk("sat.upd_count", bp.upd_count, 32'hFFFF_FFFF);
        chk("sat.miss_count", bp.miss_count, 32'hFFFF_FFFF);

        // Reset together with an update: update dropped, everything cleared
        bp.upd_valid   = 1'b1;
        bp.upd_pc      = 32'h1C0;
        bp.upd_taken   = 1'b1;
        bp.upd_target  = 32'h999;
        bp.upd_mispred = 1'b1;
        reset          = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bp.upd_valid = 1'b0;
        look("rst2.180", 32'h180, 1'b0, 32'h184);
        look("rst2.1c0", 32'h1C0, 1'b0, 32'h1C4);
        chk("rst2.upd_count", bp.upd_count, 32'd0);
        chk("rst2.miss_count", bp.miss_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
